tx_burst_scheduler: RTL and testbench
=====================================

// Module: tx_burst_scheduler
// PURPOSE
//  Turns operator requests into fan-command packet bursts. Sources: UART bytes and four push-buttons.
//  Requests are queued in a small FIFO and played back one burst at a time.
//  Each burst drives the packet generator with PACKETS_PER_BURST start pulses, separated by a fixed gap.
//  Sits between async_receiver/button pins and packet_generator, replacing ad-hoc top-level sequencing.
// PARAMETERS
//  PACKETS_PER_BURST  63      packets sent per accepted command (1..255)
//  GAP_CYCLES         131071  clk cycles from pkt_done to the next start_packet (>=1)
//  FIFO_DEPTH         4       command queue entries; power of two, >=2
//  IDLE_CMD           3'd7    value driven on cmd while no burst has ever run
// PORTS
//  clk           in   1  system clock (12 MHz)
//  reset_n       in   1  asynchronous, active-low reset
//  rx_valid      in   1  one-cycle strobe: rx_data holds a received byte
//  rx_data       in   8  UART byte
//  btn_n         in   4  raw active-low buttons, asynchronous to clk
//  pkt_done      in   1  one-cycle strobe from generator: current packet finished
//  cmd           out  3  command code presented to generator; stable for whole burst
//  start_packet  out  1  one-cycle strobe: generator begins one packet using cmd
//  burst_active  out  1  high from burst load until the final gap expires
//  fifo_full     out  1  queue holds FIFO_DEPTH entries
//  overflow      out  1  sticky: a request was dropped because the queue was full
// BEHAVIOUR
//  Reset values (async, while reset_n=0):
//   - cmd=IDLE_CMD; start_packet=0, burst_active=0, fifo_full=0, overflow=0.
//   - FIFO empty, FSM=IDLE, all counters 0, button synchronisers preset to 1.
//   - Deassertion mid-burst is equivalent to power-up: the burst is abandoned and nothing is replayed.
//  Request decode:
//   - UART bytes "0","1","2","3" -> codes 0-3; "l" -> code 4. All other bytes are ignored.
//   - btn_n[i] passes through a 2-FF synchroniser.
//   - A synchronised falling edge (1->0) of btn_n[i] requests code i.
//   - A held button requests once only; release and re-press to request again.
//  Enqueue (at most one per cycle):
//   - Priority: valid UART code, then lowest-index button edge.
//   - Losing requests in the same cycle are discarded without setting overflow.
//  FIFO rules:
//   - Push while full: entry dropped, overflow<=1. overflow stays set until reset.
//   - Push and pop in the same cycle while full: both succeed, occupancy unchanged, no overflow.
//   - fifo_full is registered and reflects occupancy after this cycle's push/pop.
//  FSM states and transitions:
//   - IDLE: if FIFO non-empty -> pop head into cmd; pkt_left<=PACKETS_PER_BURST; burst_active<=1; go START.
//   - START: start_packet=1 for exactly one cycle; pkt_left<=pkt_left-1; go WAIT.
//   - WAIT: stay until pkt_done=1; then gap_cnt<=GAP_CYCLES-1; go GAP. A pkt_done seen in any other state is ignored.
//   - GAP: decrement gap_cnt. At gap_cnt==0: if pkt_left!=0 and no abort -> START; else burst_active<=0, go IDLE.
//  Timing:
//   - Latency from enqueue into an empty FIFO with FSM in IDLE to start_packet: 2 cycles (push, pop, START).
//   - Between bursts, IDLE lasts at least 1 cycle.
//   - cmd keeps the last burst's code after the burst ends; it never changes outside the IDLE->START load.
//  Counter widths:
//   - pkt_left is $clog2(PACKETS_PER_BURST+1) bits and never underflows.
//   - gap_cnt is $clog2(GAP_CYCLES) bits (min 1).
//   - FIFO pointers wrap modulo FIFO_DEPTH; occupancy is $clog2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  ABORT_ON_NEW_CMD_EN defined:
//   - Any successful push while burst_active=1 sets abort_pending.
//   - The packet in flight completes and its GAP is still honoured.
//   - At gap expiry the FSM goes to IDLE regardless of pkt_left, then starts the queued command.
//   - abort_pending clears on entry to IDLE.
//  ABORT_ON_NEW_CMD_EN undefined:
//   - Bursts always run to completion.
//   - New requests wait in the FIFO; abort_pending logic is absent.
// TESTING (PACKETS_PER_BURST=3, GAP_CYCLES=10, FIFO_DEPTH=2; generator model returns pkt_done 5 cycles after start_packet)
//  1. Reset, then rx_valid with rx_data="2".
//     -> start_packet 2 cycles later with cmd=2; exactly 3 start pulses, each 15 cycles apart.
//     -> burst_active falls 10 cycles after the 3rd pkt_done.
//  2. rx_data="x", then "9".
//     -> no enqueue, no start_packet, cmd stays 7.
//  3. Hold btn_n[1]=0 for 100 cycles.
//     -> exactly one burst with cmd=1. Release and press again -> second burst, cmd=1.
//  4. Same-cycle UART "3" and btn_n[0] falling edge.
//     -> only code 3 queued, one burst, overflow=0.
//  5. During a burst, push "0","1","2".
//     -> fifo_full=1 after the 2nd push, "2" dropped, overflow=1.
//     -> bursts with cmd=0 then cmd=1 follow in order.
//  6. Assert reset_n=0 during GAP of packet 2.
//     -> all outputs return to reset values immediately; no further start_packet after release.
//     -> With ABORT_ON_NEW_CMD_EN: pushing "1" during packet 1 of a cmd=0 burst -> only 1 cmd=0 packet, then a cmd=1 burst.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// Queues UART/button command requests and replays each as a burst of start_packet pulses.
// Optional build macro ABORT_ON_NEW_CMD_EN: a request accepted mid-burst ends that burst after its current gap.
module tx_burst_scheduler #(
    parameter int unsigned PACKETS_PER_BURST = 63,
    parameter int unsigned GAP_CYCLES        = 131071,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter logic [2:0]  IDLE_CMD          = 3'd7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [3:0] btn_n,
    input  logic       pkt_done,
    output logic [2:0] cmd,
    output logic       start_packet,
    output logic       burst_active,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int unsigned PKT_W = $clog2(PACKETS_PER_BURST + 1);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [PKT_W-1:0] PKT_LOAD = PKT_W'(PACKETS_PER_BURST);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    // Button synchronisers and edge detection
    logic [3:0] btn_meta_q;
    logic [3:0] btn_sync_q;
    logic [3:0] btn_prev_q;
    logic [3:0] btn_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q <= '1;
            btn_sync_q <= '1;
            btn_prev_q <= '1;
        end else begin
            btn_meta_q <= btn_n;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    assign btn_fall = btn_prev_q & ~btn_sync_q;

    // Request decode
    logic       uart_hit;
    logic [2:0] uart_code;
    logic       btn_hit;
    logic [2:0] btn_code;
    logic       push_req;
    logic [2:0] push_code;

    always_comb begin
        uart_hit  = 1'b0;
        uart_code = 3'd0;
        if (rx_valid) begin
            case (rx_data)
                8'h30: begin uart_hit = 1'b1; uart_code = 3'd0; end
                8'h31: begin uart_hit = 1'b1; uart_code = 3'd1; end
                8'h32: begin uart_hit = 1'b1; uart_code = 3'd2; end
                8'h33: begin uart_hit = 1'b1; uart_code = 3'd3; end
                8'h6C: begin uart_hit = 1'b1; uart_code = 3'd4; end
                default: begin uart_hit = 1'b0; uart_code = 3'd0; end
            endcase
        end
    end

    // Descending scan so the lowest-index edge is the one that survives
    always_comb begin
        btn_hit  = 1'b0;
        btn_code = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (btn_fall[i]) begin
                btn_hit  = 1'b1;
                btn_code = 3'(i);
            end
        end
    end

    assign push_req  = uart_hit | btn_hit;
    assign push_code = uart_hit ? uart_code : btn_code;

    // Command FIFO
    logic [2:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             full_q;
    logic             ovf_q;
    logic             pop;
    logic             push_ok;
    logic [2:0]       head_code;

    state_t           state_q;

    assign pop       = (state_q == S_IDLE) && (occ_q != '0);
    assign push_ok   = push_req && ((occ_q != OCC_FULL) || pop);
    assign head_code = fifo_mem_q[rd_ptr_q];

    always_comb begin
        occ_d = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_ok && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= push_code;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q  <= occ_d;
            full_q <= (occ_d == OCC_FULL);
            if (push_req && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Burst sequencer. The pkt_done cycle is counted as the first gap cycle, so the next
    // start lands exactly GAP_CYCLES after pkt_done; gap_cnt holds the cycles still to go.
    logic [PKT_W-1:0] pkt_left_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [2:0]       cmd_q;
    logic             start_q;
    logic             active_q;
    logic             gap_expire;
    logic             abort_now;
    logic             more_pkts;

    assign gap_expire = ((state_q == S_GAP) && (gap_cnt_q <= GAP_ONE)) ||
                        ((state_q == S_WAIT) && pkt_done && (GAP_CYCLES == 1));
    assign more_pkts  = (pkt_left_q != '0) && !abort_now;

`ifdef ABORT_ON_NEW_CMD_EN
    logic abort_pending_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort_pending_q <= 1'b0;
        end else if (gap_expire && !more_pkts) begin
            abort_pending_q <= 1'b0;
        end else if (push_ok && active_q) begin
            abort_pending_q <= 1'b1;
        end
    end

    assign abort_now = abort_pending_q;
`else
    assign abort_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pkt_left_q <= '0;
            gap_cnt_q  <= '0;
            cmd_q      <= IDLE_CMD;
            start_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cmd_q      <= head_code;
                        pkt_left_q <= PKT_LOAD;
                        active_q   <= 1'b1;
                        start_q    <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (pkt_left_q != '0) begin
                        pkt_left_q <= pkt_left_q - 1'b1;
                    end
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (pkt_done) begin
                        gap_cnt_q <= GAP_LOAD;
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (gap_expire) begin
                if (more_pkts) begin
                    start_q <= 1'b1;
                    state_q <= S_START;
                end else begin
                    active_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            end
        end
    end

    assign cmd          = cmd_q;
    assign start_packet = start_q;
    assign burst_active = active_q;
    assign fifo_full    = full_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Bench for tx_burst_scheduler: decode table, scoreboarded start commands, hand-built timing corners.
`timescale 1ns/1ps
module tb_tx_burst_scheduler;
    localparam int PPB   = 3;
    localparam int GAP   = 10;
    localparam int DEPTH = 2;
    localparam int NV    = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [3:0] btn_n;
    logic       pkt_done;
    logic [2:0] cmd;
    logic       start_packet;
    logic       burst_active;
    logic       fifo_full;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int last_cmd;

    typedef struct packed {
        logic [7:0] data;
        logic       hit;
        logic [2:0] code;
    } vec_t;
    vec_t vec [NV];

    always #5 clk = ~clk;

    tx_burst_scheduler #(
        .PACKETS_PER_BURST(PPB),
        .GAP_CYCLES       (GAP),
        .FIFO_DEPTH       (DEPTH),
        .IDLE_CMD         (3'd7)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .btn_n       (btn_n),
        .pkt_done    (pkt_done),
        .cmd         (cmd),
        .start_packet(start_packet),
        .burst_active(burst_active),
        .fifo_full   (fifo_full),
        .overflow    (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_burst(input int code);
        repeat (PPB) exp_q.push_back(code);
    endtask

    task automatic wait_start(input int bound, output int n);
        n = 0;
        while (!start_packet && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || burst_active) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, (exp_q.size() == 0 && !burst_active) ? 1 : 0, 1);
        tick(5);
    endtask

    // Generator model: pkt_done one cycle wide, 5 cycles after start_packet
    initial begin
        pkt_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && start_packet) begin
                repeat (5) @(negedge clk);
                pkt_done = 1'b1;
                @(negedge clk);
                pkt_done = 1'b0;
            end
        end
    end

    // Scoreboard: every start_packet consumes one expected command code
    always @(negedge clk) begin
        if (reset_n && start_packet) begin
            check("start_expected", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                check("start_cmd", int'(cmd), exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec[0] = '{8'h78, 1'b0, 3'd0};
        vec[1] = '{8'h39, 1'b0, 3'd0};
        vec[2] = '{8'h30, 1'b1, 3'd0};
        vec[3] = '{8'h31, 1'b1, 3'd1};
        vec[4] = '{8'h33, 1'b1, 3'd3};
        vec[5] = '{8'h6C, 1'b1, 3'd4};
        vec[6] = '{8'h34, 1'b0, 3'd0};
        vec[7] = '{8'h4C, 1'b0, 3'd0};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        btn_n    = 4'hF;
        last_cmd = 7;
        tick(3);
        check("rst_cmd", int'(cmd), 7);
        check("rst_start", int'(start_packet), 0);
        check("rst_active", int'(burst_active), 0);
        check("rst_full", int'(fifo_full), 0);
        check("rst_ovf", int'(overflow), 0);
        reset_n = 1'b1;
        tick(2);

        // Decode table: ignored bytes first so cmd must still be the idle code
        for (int i = 0; i < NV; i++) begin
            if (vec[i].hit) begin
                expect_burst(int'(vec[i].code));
                last_cmd = int'(vec[i].code);
            end
            send_byte(vec[i].data);
            tick(3);
            check($sformatf("vec%0d_active", i), int'(burst_active), int'(vec[i].hit));
            drain($sformatf("vec%0d_drain", i));
            check($sformatf("vec%0d_cmd", i), int'(cmd), last_cmd);
        end

        // Burst timing: 2-cycle latency, 15-cycle spacing, active falls 10 after last pkt_done
        expect_burst(2);
        send_byte(8'h32);
        check("t1_no_early_start", int'(start_packet), 0);
        tick(1);
        check("t1_latency_start", int'(start_packet), 1);
        check("t1_active", int'(burst_active), 1);
        for (int k = 2; k <= PPB; k++) begin
            tick(1);
            wait_start(40, n);
            check($sformatf("t1_spacing%0d", k), n + 1, 15);
        end
        n = 0;
        while (burst_active && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_active_fall", n, 15);
        drain("t1_drain");

        // Held button requests once; re-press requests again
        expect_burst(1);
        btn_n[1] = 1'b0;
        tick(100);
        check("t3_one_burst", exp_q.size(), 0);
        check("t3_idle", int'(burst_active), 0);
        btn_n = 4'hF;
        tick(5);
        expect_burst(1);
        btn_n[1] = 1'b0;
        tick(3);
        btn_n = 4'hF;
        drain("t3_drain");
        check("t3_cmd", int'(cmd), 1);

        // UART and button edge in the same cycle: UART wins, button dropped silently
        btn_n[0] = 1'b0;
        tick(2);
        expect_burst(3);
        send_byte(8'h33);
        drain("t4_drain");
        check("t4_ovf", int'(overflow), 0);
        btn_n = 4'hF;
        tick(5);

        // Overflow while a burst is running
        expect_burst(3);
        send_byte(8'h33);
        wait_start(10, n);
        check("t5_latency", n, 1);
        tick(2);
        expect_burst(0);
        send_byte(8'h30);
        check("t5_full_after1", int'(fifo_full), 0);
        expect_burst(1);
        send_byte(8'h31);
        check("t5_full_after2", int'(fifo_full), 1);
        check("t5_ovf_before", int'(overflow), 0);
        send_byte(8'h32);
        check("t5_ovf_set", int'(overflow), 1);
        drain("t5_drain");
        check("t5_ovf_sticky", int'(overflow), 1);
        check("t5_full_clear", int'(fifo_full), 0);
        check("t5_cmd", int'(cmd), 1);

        // Reset during the gap after packet 2
        expect_burst(2);
        send_byte(8'h32);
        wait_start(10, n);
        tick(1);
        wait_start(40, n);
        check("t6_second_start", int'(start_packet), 1);
        tick(8);
        check("t6_in_gap", int'(burst_active), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_cmd", int'(cmd), 7);
        check("t6_rst_start", int'(start_packet), 0);
        check("t6_rst_active", int'(burst_active), 0);
        check("t6_rst_full", int'(fifo_full), 0);
        check("t6_rst_ovf", int'(overflow), 0);
        exp_q.delete();
        tick(2);
        reset_n = 1'b1;
        tick(40);
        check("t6_no_replay", int'(burst_active), 0);
        check("t6_cmd_idle", int'(cmd), 7);

`ifdef ABORT_ON_NEW_CMD_EN
        // New request during packet 1 truncates the burst after its gap
        exp_q.push_back(0);
        send_byte(8'h30);
        wait_start(10, n);
        tick(2);
        expect_burst(1);
        send_byte(8'h31);
        drain("ab_drain");
        check("ab_cmd", int'(cmd), 1);
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
